vj_rect_sum_reader: RTL and testbench

Downstream consumer of the integral-image builder. Accepts rectangle requests (top-left pixel, width, height), issues four corner reads to the integral-image RAM (321×241, row stride 321), and returns the rectangle pixel sum D − B − C + A through a valid/ready handshake. The block only serves requests between the builder's `build_done` and the next `frame_start`. It feeds the Haar feature evaluator.

---
 rtl/vj_rect_sum_reader_if.sv | 41 ++++
 rtl/vj_rect_sum_reader.sv | 151 +++++++++++++++
 tb/tb_vj_rect_sum_reader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/vj_rect_sum_reader_if.sv
// rtl/vj_rect_sum_reader_if.sv - request, result and integral-image RAM signals of vj_rect_sum_reader
// req_weight exists only when VJ_RECT_WEIGHT_EN is defined.
interface vj_rect_sum_reader_if #(
  parameter int ADDR_W    = 17,
  parameter int II_DATA_W = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [8:0]           req_x;
  logic [7:0]           req_y;
  logic [8:0]           req_w;
  logic [7:0]           req_h;
`ifdef VJ_RECT_WEIGHT_EN
  logic [2:0]           req_weight;
`endif
  logic                 ii_re;
  logic [ADDR_W-1:0]    ii_raddr;
  logic [II_DATA_W-1:0] ii_rdata;
  logic                 sum_valid;
  logic                 sum_ready;
  logic [II_DATA_W-1:0] sum;
  logic                 sum_err;

  modport master (
    output req_valid, req_x, req_y, req_w, req_h,
`ifdef VJ_RECT_WEIGHT_EN
    output req_weight,
`endif
    output ii_rdata, sum_ready,
    input  req_ready, ii_re, ii_raddr, sum_valid, sum, sum_err
  );

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h,
`ifdef VJ_RECT_WEIGHT_EN
    input  req_weight,
`endif
    input  ii_rdata, sum_ready,
    output req_ready, ii_re, ii_raddr, sum_valid, sum, sum_err
  );
endinterface

// File: rtl/vj_rect_sum_reader.sv
// rtl/vj_rect_sum_reader.sv - four-corner integral-image rectangle sum reader
// Optional VJ_RECT_WEIGHT_EN: signed 3-bit weight multiply, one extra cycle of latency.
module vj_rect_sum_reader #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int II_W      = 321,
  parameter int ADDR_W    = 17,
  parameter int II_DATA_W = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_start,
  input  logic build_done,
  output logic ii_avail,
  vj_rect_sum_reader_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_RD_C, S_RD_D, S_WAIT, S_MUL, S_DONE
  } state_t;

  localparam logic [9:0] IMG_W_L = 10'(IMG_W);
  localparam logic [8:0] IMG_H_L = 9'(IMG_H);

  state_t               state, state_next;
  logic [9:0]           x_q, xe_q;
  logic [8:0]           y_q, ye_q;
  logic [II_DATA_W-1:0] acc;
  logic [II_DATA_W-1:0] sum_q, sum_final;
  logic                 sum_err_q;
  logic                 re_q, re_next;
  logic [ADDR_W-1:0]    raddr_q, raddr_next;
  logic                 avail_q;
  logic                 accept, req_ok;
  logic [9:0]           xe_in;
  logic [8:0]           ye_in;

  function automatic logic [ADDR_W-1:0] ii_addr(input logic [9:0] col, input logic [8:0] row);
    ii_addr = ADDR_W'(row) * ADDR_W'(II_W) + ADDR_W'(col);
  endfunction

  assign bus.req_ready = avail_q && (state == S_IDLE);
  assign bus.sum_valid = (state == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.sum_err   = sum_err_q;
  assign bus.ii_re     = re_q;
  assign bus.ii_raddr  = raddr_q;
  assign ii_avail      = avail_q;

  assign accept = bus.req_valid && bus.req_ready;
  assign xe_in  = {1'b0, bus.req_x} + {1'b0, bus.req_w};
  assign ye_in  = {1'b0, bus.req_y} + {1'b0, bus.req_h};
  assign req_ok = (bus.req_w != '0) && (bus.req_h != '0) && (xe_in <= IMG_W_L) && (ye_in <= IMG_H_L);

`ifdef VJ_RECT_WEIGHT_EN
  logic [2:0]           weight_q;
  logic [II_DATA_W-1:0] weight_ext;
  assign weight_ext = {{(II_DATA_W-3){weight_q[2]}}, weight_q};
  // Low II_DATA_W bits of the product are the same signed or unsigned.
  assign sum_final  = acc * weight_ext;
`else
  assign sum_final  = acc + bus.ii_rdata;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = req_ok ? S_RD_A : S_DONE;
      S_RD_A: state_next = S_RD_B;
      S_RD_B: state_next = S_RD_C;
      S_RD_C: state_next = S_RD_D;
      S_RD_D: state_next = S_WAIT;
`ifdef VJ_RECT_WEIGHT_EN
      S_WAIT: state_next = S_MUL;
`else
      S_WAIT: state_next = S_DONE;
`endif
      S_MUL:  state_next = S_DONE;
      S_DONE: if (bus.sum_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (frame_start) state_next = S_IDLE;
  end

  // Corner address for the read issued in the cycle after this edge.
  always_comb begin
    re_next    = 1'b1;
    raddr_next = raddr_q;
    case (state_next)
      S_RD_A:  raddr_next = ii_addr({1'b0, bus.req_x}, {1'b0, bus.req_y});
      S_RD_B:  raddr_next = ii_addr(xe_q, y_q);
      S_RD_C:  raddr_next = ii_addr(x_q, ye_q);
      S_RD_D:  raddr_next = ii_addr(xe_q, ye_q);
      default: re_next    = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      re_q      <= 1'b0;
      raddr_q   <= '0;
      sum_q     <= '0;
      sum_err_q <= 1'b0;
      avail_q   <= 1'b0;
      acc       <= '0;
      x_q       <= '0;
      xe_q      <= '0;
      y_q       <= '0;
      ye_q      <= '0;
`ifdef VJ_RECT_WEIGHT_EN
      weight_q  <= '0;
`endif
    end else begin
      state   <= state_next;
      re_q    <= re_next;
      raddr_q <= raddr_next;

      if (frame_start)     avail_q <= 1'b0;
      else if (build_done) avail_q <= 1'b1;

      if (state == S_IDLE && accept) begin
        x_q  <= {1'b0, bus.req_x};
        y_q  <= {1'b0, bus.req_y};
        xe_q <= xe_in;
        ye_q <= ye_in;
`ifdef VJ_RECT_WEIGHT_EN
        weight_q <= bus.req_weight;
`endif
      end

      // Each datum arrives one state after its read was issued.
      case (state)
        S_RD_B: acc <= bus.ii_rdata;
        S_RD_C: acc <= acc - bus.ii_rdata;
        S_RD_D: acc <= acc - bus.ii_rdata;
        S_WAIT: acc <= acc + bus.ii_rdata;
        default: ;
      endcase

      if (state_next == S_DONE && state != S_DONE) begin
        if (state == S_IDLE) begin
          sum_q     <= '0;
          sum_err_q <= 1'b1;
        end else begin
          sum_q     <= sum_final;
          sum_err_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_vj_rect_sum_reader.sv
// tb/tb_vj_rect_sum_reader.sv - directed bench for vj_rect_sum_reader
// Build with VJ_RECT_WEIGHT_EN defined to also cover the weighted path.
module tb_vj_rect_sum_reader;
  logic clk = 1'b0;
  logic reset_n;
  logic frame_start;
  logic build_done;
  logic ii_avail;
  int   checks = 0;
  int   errors = 0;

`ifdef VJ_RECT_WEIGHT_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  vj_rect_sum_reader_if bus ();

  vj_rect_sum_reader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .build_done  (build_done),
    .ii_avail    (ii_avail),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // All-ones image: II(x,y) = x*y at address y*321 + x.
  always @(posedge clk) begin
    if (bus.ii_re) bus.ii_rdata <= 32'((int'(bus.ii_raddr) % 321) * (int'(bus.ii_raddr) / 321));
    else           bus.ii_rdata <= 32'hDEADBEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_build();
    build_done = 1'b1;
    tick();
    build_done = 1'b0;
  endtask

  task automatic run_req(input string tag, input int x, input int y, input int w, input int h,
                         input int wt, input logic [31:0] exp_sum, input logic exp_err, input int hold);
    int ea[4];
    int lat;
    logic [31:0] held;
    ea[0] = y * 321 + x;
    ea[1] = y * 321 + x + w;
    ea[2] = (y + h) * 321 + x;
    ea[3] = (y + h) * 321 + x + w;
    bus.sum_ready = (hold == 0);
    bus.req_valid = 1'b1;
    bus.req_x = 9'(x);
    bus.req_y = 8'(y);
    bus.req_w = 9'(w);
    bus.req_h = 8'(h);
`ifdef VJ_RECT_WEIGHT_EN
    bus.req_weight = 3'(wt);
`else
    if (wt != 0) lat = 0;
`endif
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    lat = 0;
    if (exp_err) begin
      check({tag, "_no_re"}, 32'(bus.ii_re), 32'd0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        check({tag, "_re"}, 32'(bus.ii_re), 32'd1);
        check({tag, "_addr"}, 32'(bus.ii_raddr), 32'(ea[k]));
        if (k == 0) check({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
        tick();
        lat++;
      end
    end
    while (!bus.sum_valid && lat < 12) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), exp_err ? 32'd0 : 32'(LAT));
    check({tag, "_sum"}, bus.sum, exp_sum);
    check({tag, "_err"}, 32'(bus.sum_err), 32'(exp_err));
    held = bus.sum;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(bus.sum_valid), 32'd1);
      check({tag, "_hold_sum"}, bus.sum, held);
      check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.sum_ready = 1'b1;
    tick();
    check({tag, "_released"}, 32'(bus.sum_valid), 32'd0);
    check({tag, "_ready_again"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    reset_n = 1'b0;
    frame_start = 1'b0;
    build_done = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_w = '0;
    bus.req_h = '0;
`ifdef VJ_RECT_WEIGHT_EN
    bus.req_weight = 3'd1;
`endif
    bus.sum_ready = 1'b1;
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_ii_re", 32'(bus.ii_re), 32'd0);
    check("rst_ii_raddr", 32'(bus.ii_raddr), 32'd0);
    check("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
    check("rst_sum", bus.sum, 32'd0);
    check("rst_sum_err", 32'(bus.sum_err), 32'd0);
    check("rst_ii_avail", 32'(ii_avail), 32'd0);
    reset_n = 1'b1;
    tick();

    bus.req_valid = 1'b1;
    bus.req_w = 9'd4;
    bus.req_h = 8'd4;
    for (int i = 0; i < 4; i++) begin
      check("pre_build_ready", 32'(bus.req_ready), 32'd0);
      tick();
      check("pre_build_re", 32'(bus.ii_re), 32'd0);
    end
    bus.req_valid = 1'b0;

    pulse_build();
    check("avail_set", 32'(ii_avail), 32'd1);

    run_req("basic", 10, 20, 4, 8, 1, 32'd32, 1'b0, 0);
    run_req("full", 0, 0, 320, 240, 1, 32'd76800, 1'b0, 0);
    run_req("corner", 319, 239, 1, 1, 1, 32'd1, 1'b0, 0);
    run_req("x_over", 318, 0, 4, 1, 3, 32'd0, 1'b1, 0);
    run_req("w_zero", 0, 0, 0, 1, 3, 32'd0, 1'b1, 0);
    run_req("y_over", 0, 239, 1, 2, 3, 32'd0, 1'b1, 0);
    run_req("bp", 100, 50, 7, 9, 1, 32'd63, 1'b0, 10);

    bus.req_x = 9'd10;
    bus.req_y = 8'd20;
    bus.req_w = 9'd4;
    bus.req_h = 8'd8;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("abort_re", 32'(bus.ii_re), 32'd0);
    check("abort_valid", 32'(bus.sum_valid), 32'd0);
    check("abort_avail", 32'(ii_avail), 32'd0);
    check("abort_ready", 32'(bus.req_ready), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.sum_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);

    pulse_build();
    check("rebuild_avail", 32'(ii_avail), 32'd1);
    frame_start = 1'b1;
    build_done = 1'b1;
    tick();
    frame_start = 1'b0;
    build_done = 1'b0;
    check("both_avail", 32'(ii_avail), 32'd0);
    pulse_build();
    run_req("after_abort", 5, 5, 3, 2, 1, 32'd6, 1'b0, 0);

`ifdef VJ_RECT_WEIGHT_EN
    run_req("wt_neg1", 10, 20, 4, 8, -1, 32'hFFFFFFE0, 1'b0, 0);
    run_req("wt_3", 10, 20, 4, 8, 3, 32'd96, 1'b0, 0);
    run_req("wt_0", 10, 20, 4, 8, 0, 32'd0, 1'b0, 0);
    run_req("wt_neg4", 0, 0, 2, 3, -4, 32'hFFFFFFE8, 1'b0, 0);
    run_req("wt_invalid", 318, 0, 4, 1, 3, 32'd0, 1'b1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
